net_stat_cnt_array: RTL and testbench

- Parametrised statistics counter bank for the network stack. It is the generalised successor of the fixed-field net_stat_t collection.
- Sums per-cycle event increments from N_CNT sources into wide counters, with wrap or saturate mode and sticky overflow flags.
- Supports atomic snapshot and clear, a delayed flat snapshot bus for the shell stats path, and a registered indexed read port for AXI-Lite readout.
- Sits in the network clock domain between the RoCE/TCP/ARP datapaths and the stats register file.

---
 rtl/net_stat_cnt_array_pkg.sv | 34 +++
 rtl/net_stat_cnt_array_slice.sv | 60 ++++++
 rtl/net_stat_cnt_array.sv | 115 +++++++++++
 tb/tb_net_stat_cnt_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/net_stat_cnt_array_pkg.sv
`default_nettype none
// ==========================================================================
// net_stat_cnt_array_pkg : network statistics counter constants and types
// Rev 1.0
// ==========================================================================
package net_stat_cnt_array_pkg;

   localparam int N_NET_STAT_CNT    = 16;
   localparam int NET_STAT_CNT_BITS = 32;

   localparam int STAT_RX_PKG        = 0;
   localparam int STAT_TX_PKG        = 1;
   localparam int STAT_ARP_RX        = 2;
   localparam int STAT_ARP_TX        = 3;
   localparam int STAT_ICMP_RX       = 4;
   localparam int STAT_ICMP_TX       = 5;
   localparam int STAT_TCP_RX        = 6;
   localparam int STAT_TCP_TX        = 7;
   localparam int STAT_ROCE_RX       = 8;
   localparam int STAT_ROCE_TX       = 9;
   localparam int STAT_IBV_DROP      = 10;
   localparam int STAT_ROCE_PSN_DROP = 11;
   localparam int STAT_ROCE_RETRY    = 12;
   localparam int STAT_ROCE_RETRANS  = 13;

   typedef logic [N_NET_STAT_CNT-1:0][NET_STAT_CNT_BITS-1:0] net_stat_vec_t;

   // Index width that never collapses to zero bits for a single counter.
   function automatic int clog2s(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/net_stat_cnt_array_slice.sv
`default_nettype none
// ==========================================================================
// stat_cnt_slice : one statistics counter with wrap/saturate, snapshot, ovf
// Rev 1.0
// ==========================================================================
module stat_cnt_slice
   import net_stat_cnt_array_pkg::*;
#(
   parameter int CNT_BITS = NET_STAT_CNT_BITS,
   parameter int INC_BITS = 4,
   parameter int SAT_MODE = 0
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [INC_BITS-1:0] inc,
   input  logic                clr,
   input  logic                snap,
   output logic [CNT_BITS-1:0] cnt,
   output logic [CNT_BITS-1:0] snap_val,
   output logic                ovf
);

   logic [CNT_BITS:0]   sum;
   logic                carry;
   logic [CNT_BITS-1:0] nxt;
   logic [CNT_BITS-1:0] cnt_d, cnt_q;
   logic [CNT_BITS-1:0] snap_d, snap_q;
   logic                ovf_d, ovf_q;

   // The snapshot takes the post-increment value so clear-on-read loses nothing.
   always_comb begin
      sum   = {1'b0, cnt_q} + {{(CNT_BITS + 1 - INC_BITS){1'b0}}, inc};
      carry = sum[CNT_BITS];
      nxt   = sum[CNT_BITS-1:0];
      if ((SAT_MODE != 0) && carry) begin
         nxt = '1;
      end
      cnt_d  = clr  ? '0 : nxt;
      ovf_d  = clr  ? 1'b0 : (ovf_q | carry);
      snap_d = snap ? nxt : snap_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q  <= '0;
         snap_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cnt      = cnt_q;
   assign snap_val = snap_q;
   assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: rtl/net_stat_cnt_array.sv
`default_nettype none
// ==========================================================================
// net_stat_cnt_array : parametrised stats counter bank with snapshot and read
// Rev 1.0
// ==========================================================================
module net_stat_cnt_array
   import net_stat_cnt_array_pkg::*;
#(
   parameter int N_CNT    = N_NET_STAT_CNT,
   parameter int CNT_BITS = NET_STAT_CNT_BITS,
   parameter int INC_BITS = 4,
   parameter int SAT_MODE = 0,
   parameter int N_STAGES = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [N_CNT*INC_BITS-1:0]   evt_inc,
   input  logic                        clr,
   input  logic                        snap,
   output logic [N_CNT*CNT_BITS-1:0]   snap_data,
   output logic                        snap_valid,
   output logic [N_CNT-1:0]            ovf,
   input  logic                        rd_req,
   input  logic [clog2s(N_CNT)-1:0]    rd_idx,
   output logic [CNT_BITS-1:0]         rd_data,
   output logic                        rd_valid
);

   localparam int IDX_W = clog2s(N_CNT);

   logic [N_CNT-1:0][CNT_BITS-1:0] cnt_arr;
   logic [N_CNT-1:0][CNT_BITS-1:0] snap_arr;

   for (genvar i = 0; i < N_CNT; i++) begin : g_slice
      stat_cnt_slice #(
         .CNT_BITS (CNT_BITS),
         .INC_BITS (INC_BITS),
         .SAT_MODE (SAT_MODE)
      ) u_slice (
         .aclk     (aclk),
         .aresetn  (aresetn),
         .inc      (evt_inc[i*INC_BITS +: INC_BITS]),
         .clr      (clr),
         .snap     (snap),
         .cnt      (cnt_arr[i]),
         .snap_val (snap_arr[i]),
         .ovf      (ovf[i])
      );
   end

   logic [CNT_BITS-1:0] rd_sel;
   logic [CNT_BITS-1:0] rd_data_d, rd_data_q;
   logic                rd_valid_d, rd_valid_q;
   logic                snap_vld0_d, snap_vld0_q;

   // Indices with no matching counter fall through to zero.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < N_CNT; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_sel = cnt_arr[i];
         end
      end
      rd_data_d   = rd_req ? rd_sel : rd_data_q;
      rd_valid_d  = rd_req;
      snap_vld0_d = snap;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         snap_vld0_q <= 1'b0;
      end else begin
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         snap_vld0_q <= snap_vld0_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   if (N_STAGES > 0) begin : g_pipe
      logic [N_STAGES-1:0][N_CNT*CNT_BITS-1:0] stg_d, stg_q;
      logic [N_STAGES-1:0]                     stv_d, stv_q;

      always_comb begin
         stg_d[0] = snap_arr;
         stv_d[0] = snap_vld0_q;
         for (int k = 1; k < N_STAGES; k++) begin
            stg_d[k] = stg_q[k-1];
            stv_d[k] = stv_q[k-1];
         end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            stg_q <= '0;
            stv_q <= '0;
         end else begin
            stg_q <= stg_d;
            stv_q <= stv_d;
         end
      end

      assign snap_data  = stg_q[N_STAGES-1];
      assign snap_valid = stv_q[N_STAGES-1];
   end else begin : g_nopipe
      assign snap_data  = snap_arr;
      assign snap_valid = snap_vld0_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_net_stat_cnt_array.sv
`default_nettype none
// ==========================================================================
// tb_net_stat_cnt_array : scoreboard bench, wrap and saturate banks side by side
// Rev 1.0
// ==========================================================================
module tb_net_stat_cnt_array;

   localparam int N    = 6;
   localparam int CB   = 8;
   localparam int IB   = 4;
   localparam int NST  = 4;
   localparam int MAXV = (1 << CB) - 1;

   typedef struct {
      int               cyc;
      logic [N*CB-1:0]  data;
   } exp_t;

   logic            clk = 1'b0;
   logic            aresetn = 1'b1;
   logic [N*IB-1:0] evt_inc = '0;
   logic            clr = 1'b0;
   logic            snap = 1'b0;
   logic            rd_req = 1'b0;
   logic [2:0]      rd_idx = '0;

   logic [N*CB-1:0] snap_data_w [2];
   logic            snap_valid_w [2];
   logic [N-1:0]    ovf_w [2];
   logic [CB-1:0]   rd_data_w [2];
   logic            rd_valid_w [2];

   always #5 clk = ~clk;

   net_stat_cnt_array #(.N_CNT(N), .CNT_BITS(CB), .INC_BITS(IB), .SAT_MODE(0), .N_STAGES(NST)) u_wrap (
      .aclk(clk), .aresetn(aresetn), .evt_inc(evt_inc), .clr(clr), .snap(snap),
      .snap_data(snap_data_w[0]), .snap_valid(snap_valid_w[0]), .ovf(ovf_w[0]),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]));

   net_stat_cnt_array #(.N_CNT(N), .CNT_BITS(CB), .INC_BITS(IB), .SAT_MODE(1), .N_STAGES(NST)) u_sat (
      .aclk(clk), .aresetn(aresetn), .evt_inc(evt_inc), .clr(clr), .snap(snap),
      .snap_data(snap_data_w[1]), .snap_valid(snap_valid_w[1]), .ovf(ovf_w[1]),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]));

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   mcnt [2][N];
   bit   movf [2][N];
   exp_t rdq [2][$];
   exp_t snq [2][$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: unbounded integer sum, then wrap modulo 2^CB or clamp to max.
   task automatic model_step();
      exp_t e;
      logic [N*CB-1:0] sv;
      int s, nv;
      for (int m = 0; m < 2; m++) begin
         if (rd_req) begin
            e.cyc  = cyc;
            e.data = (int'(rd_idx) < N) ? (N*CB)'(mcnt[m][rd_idx]) : '0;
            rdq[m].push_back(e);
         end
         sv = '0;
         for (int i = 0; i < N; i++) begin
            s  = mcnt[m][i] + int'(evt_inc[i*IB +: IB]);
            nv = (m == 0) ? (s % (MAXV + 1)) : ((s > MAXV) ? MAXV : s);
            sv[i*CB +: CB] = CB'(nv);
            if (s > MAXV) movf[m][i] = 1'b1;
            mcnt[m][i] = nv;
            if (clr) begin
               mcnt[m][i] = 0;
               movf[m][i] = 1'b0;
            end
         end
         if (snap) begin
            e.cyc  = cyc + NST;
            e.data = sv;
            snq[m].push_back(e);
         end
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            mcnt[m][i] = 0;
            movf[m][i] = 1'b0;
         end
         rdq[m].delete();
         snq[m].delete();
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (aresetn) begin
         cyc++;
         model_step();
      end
      #1;
   endtask

   task automatic run(input logic [N*IB-1:0] inc, input bit c, input bit s, input bit r, input logic [2:0] idx);
      evt_inc = inc;
      clr     = c;
      snap    = s;
      rd_req  = r;
      rd_idx  = idx;
      tick();
   endtask

   // Monitor: pops the scoreboard whenever a DUT valid appears.
   initial begin
      exp_t e;
      logic [N-1:0] ev;
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            if (!aresetn) begin
               check("rst_snap_data", 64'(snap_data_w[m]), 64'd0);
               check("rst_snap_valid", 64'(snap_valid_w[m]), 64'd0);
               check("rst_ovf", 64'(ovf_w[m]), 64'd0);
               check("rst_rd_data", 64'(rd_data_w[m]), 64'd0);
               check("rst_rd_valid", 64'(rd_valid_w[m]), 64'd0);
            end else begin
               for (int i = 0; i < N; i++) ev[i] = movf[m][i];
               check(m == 0 ? "ovf_wrap" : "ovf_sat", 64'(ovf_w[m]), 64'(ev));
               if (rd_valid_w[m]) begin
                  if (rdq[m].size() == 0) begin
                     check("rd_valid_unexpected", 64'(rd_valid_w[m]), 64'd0);
                  end else begin
                     e = rdq[m].pop_front();
                     check("rd_latency", 64'(cyc), 64'(e.cyc));
                     check(m == 0 ? "rd_data_wrap" : "rd_data_sat", 64'(rd_data_w[m]), 64'(e.data));
                  end
               end else if (rdq[m].size() != 0 && rdq[m][0].cyc <= cyc) begin
                  void'(rdq[m].pop_front());
                  check("rd_valid_missing", 64'(rd_valid_w[m]), 64'd1);
               end
               if (snap_valid_w[m]) begin
                  if (snq[m].size() == 0) begin
                     check("snap_valid_unexpected", 64'(snap_valid_w[m]), 64'd0);
                  end else begin
                     e = snq[m].pop_front();
                     check("snap_latency", 64'(cyc), 64'(e.cyc));
                     check(m == 0 ? "snap_data_wrap" : "snap_data_sat", 64'(snap_data_w[m]), 64'(e.data));
                  end
               end else if (snq[m].size() != 0 && snq[m][0].cyc <= cyc) begin
                  void'(snq[m].pop_front());
                  check("snap_valid_missing", 64'(snap_valid_w[m]), 64'd1);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*IB-1:0] rinc;
      model_reset();
      #2 aresetn = 1'b0;
      repeat (3) tick();
      aresetn = 1'b1;

      // Counter 0 accumulates 3 per cycle; then every index including out-of-range ones.
      repeat (10) run(24'h3, 0, 0, 0, 3'd0);
      for (int i = 0; i < 8; i++) run('0, 0, 0, 1, 3'(i));

      // Reach 254, then overflow by 5; ovf must stick until clr.
      run('0, 1, 0, 0, 3'd0);
      repeat (16) run(24'hF, 0, 0, 0, 3'd0);
      run(24'hE, 0, 0, 0, 3'd0);
      run(24'h5, 0, 0, 0, 3'd0);
      run(24'h1, 0, 0, 0, 3'd0);
      repeat (3) run('0, 0, 0, 0, 3'd0);
      run('0, 0, 0, 1, 3'd0);
      run('0, 1, 0, 0, 3'd0);

      // Reach 250, add 15, then 1 more (saturated bank must hold at max).
      repeat (16) run(24'hF, 0, 0, 0, 3'd0);
      run(24'hA, 0, 0, 0, 3'd0);
      run(24'hF, 0, 0, 0, 3'd0);
      run(24'h1, 0, 0, 1, 3'd0);
      run('0, 0, 0, 1, 3'd0);
      run('0, 1, 0, 0, 3'd0);

      // Clear-on-read at 100 with a same-cycle increment of 2.
      repeat (6) run(24'hF, 0, 0, 0, 3'd0);
      run(24'hA, 0, 0, 0, 3'd0);
      run(24'h2, 1, 1, 0, 3'd0);
      run(24'h1, 0, 0, 1, 3'd0);
      run(24'h1, 0, 0, 1, 3'd0);
      repeat (6) run('0, 0, 0, 0, 3'd0);

      // Back-to-back snapshots with all counters moving.
      run(24'h123456, 0, 1, 0, 3'd0);
      run(24'h654321, 0, 1, 0, 3'd0);
      repeat (6) run('0, 0, 0, 0, 3'd0);

      for (int k = 0; k < 1500; k++) begin
         rinc = N*IB'($urandom);
         if ($urandom_range(3) == 0) rinc = '0;
         run(rinc, ($urandom_range(49) == 0), ($urandom_range(7) == 0),
             ($urandom_range(2) == 0), 3'($urandom_range(7)));
      end
      repeat (8) run('0, 0, 0, 0, 3'd0);

      // Reset while a snapshot and a read are in flight; nothing may emerge afterwards.
      run(24'h777777, 0, 1, 1, 3'd1);
      run(24'h111111, 0, 0, 0, 3'd0);
      aresetn = 1'b0;
      model_reset();
      repeat (2) tick();
      aresetn = 1'b1;
      repeat (10) run('0, 0, 0, 0, 3'd0);
      for (int i = 0; i < N; i++) run('0, 0, 0, 1, 3'(i));
      repeat (8) run('0, 0, 0, 0, 3'd0);

      for (int m = 0; m < 2; m++) begin
         check("rd_queue_drained", 64'(rdq[m].size()), 64'd0);
         check("snap_queue_drained", 64'(snq[m].size()), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
